// File: rtl/nes_dbg_pkg.sv
// Shared types for the NES debug/run-control slice.
//   run_mode_t   : host-requested execution mode (mode input encoding)
//   halt_cause_t : reason the CPU is currently halted
//   run_state_t  : run controller state register encoding
//   idx_width()  : width of a breakpoint index, never less than 1 bit
package nes_dbg_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_BURST = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_HALT  = 2'd3
  } run_mode_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HOST = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_DONE = 2'd3
  } halt_cause_t;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_FREE   = 2'd1,
    ST_BURST  = 2'd2,
    ST_STEP   = 2'd3
  } run_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_match.sv
// Parallel PC breakpoint comparators with lowest-index priority.
// Purely combinational.
//   bp_addr : NUM_BP packed addresses, entry i at [i*PC_W +: PC_W]
//   bp_en   : per-entry enable
//   pc      : CPU address bus
//   hit     : some enabled entry equals pc
//   idx     : lowest matching entry (0 when no hit)
module bp_match
  import nes_dbg_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int PC_W   = 16
) (
  input  logic [NUM_BP*PC_W-1:0]     bp_addr,
  input  logic [NUM_BP-1:0]          bp_en,
  input  logic [PC_W-1:0]            pc,
  output logic                       hit,
  output logic [idx_width(NUM_BP)-1:0] idx
);

  localparam int IDX_W = idx_width(NUM_BP);

  // Walk from the top down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU execution controller: generates the 6502 clock enable for free-run,
// bounded burst, single-step and host-halt operation, with PC breakpoints.
// Also keeps CPU cycle parity (OAM DMA alignment) and a live cycle count.
//   clk, reset      : CPU clock, synchronous active-high reset
//   mode            : requested mode (FREE/BURST/STEP/HALT), level
//   run_pulse       : start strobe for FREE/BURST
//   step_pulse      : start strobe for STEP
//   burst_len       : burst length, sampled on run_pulse
//   bp_addr, bp_en  : breakpoint bank
//   pc, sync        : CPU address bus and opcode-fetch flag (same cycle)
//   dma_stall       : suspend CPU without halting
//   cpu_enable      : CPU clock enable (combinational)
//   odd_or_even     : CPU cycle parity
//   cycle_count     : live cycles since reset, wraps
//   halted          : state is HALTED
//   halt_cause      : 0 none, 1 host, 2 breakpoint, 3 burst/step done
//   halt_bp_idx     : breakpoint that caused the last breakpoint halt
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_HALTED  | CPU frozen, counters frozen, waiting for a start strobe
// ST_FREE    | run until breakpoint or host halt
// ST_BURST   | run until remaining granted cycles reach zero
// ST_STEP    | run one instruction; stop on the fetch after the first
module cpu_run_ctrl
  import nes_dbg_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int PC_W      = 16,
  parameter int NUM_BP    = 4,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         run_pulse,
  input  logic                         step_pulse,
  input  logic [CNT_W-1:0]             burst_len,
  input  logic [NUM_BP*PC_W-1:0]       bp_addr,
  input  logic [NUM_BP-1:0]            bp_en,
  input  logic [PC_W-1:0]              pc,
  input  logic                         sync,
  input  logic                         dma_stall,
  output logic                         cpu_enable,
  output logic                         odd_or_even,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         halted,
  output logic [1:0]                   halt_cause,
  output logic [idx_width(NUM_BP)-1:0] halt_bp_idx
);

  localparam int IDX_W = idx_width(NUM_BP);

  run_state_t        state_q, state_d;
  halt_cause_t       cause_q, cause_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic              granted_once_q, granted_once_d;
  logic              bp_skip_q, bp_skip_d;
  logic              odd_q, odd_d;

  logic              match_hit;
  logic [IDX_W-1:0]  match_idx;
  logic              live, bp_hit, step_done, stop, leave_halt;
  run_mode_t         mode_e;

  bp_match #(
    .NUM_BP (NUM_BP),
    .PC_W   (PC_W)
  ) u_bp_match (
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .pc      (pc),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  always_comb begin
    mode_e    = run_mode_t'(mode);
    live      = (state_q != ST_HALTED);
    // Breakpoints only matter while running; a halted CPU keeps its cause.
    bp_hit    = live && sync && match_hit && !bp_skip_q;
    step_done = (state_q == ST_STEP) && sync && granted_once_q;
    stop      = bp_hit || step_done;
    cpu_enable = live && !dma_stall && !stop && !reset;

    state_d        = state_q;
    cause_d        = cause_q;
    idx_d          = idx_q;
    remaining_d    = remaining_q;
    cycle_count_d  = cycle_count_q;
    granted_once_d = granted_once_q;
    bp_skip_d      = bp_skip_q;
    odd_d          = odd_q;
    leave_halt     = 1'b0;

    // Parity and cycle count track CPU time, including stalled cycles.
    if (live) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
      odd_d         = ~odd_q;
    end

    if (cpu_enable) begin
      bp_skip_d = 1'b0;
      if (state_q == ST_BURST) remaining_d = remaining_q - CNT_W'(1);
      if (state_q == ST_STEP)  granted_once_d = 1'b1;
    end

    if (state_q == ST_HALTED) begin
      if (mode_e == MODE_FREE && run_pulse) begin
        state_d    = ST_FREE;
        leave_halt = 1'b1;
      end else if (mode_e == MODE_BURST && run_pulse && (burst_len != '0)) begin
        state_d     = ST_BURST;
        remaining_d = burst_len;
        leave_halt  = 1'b1;
      end else if (mode_e == MODE_STEP && step_pulse) begin
        state_d        = ST_STEP;
        granted_once_d = 1'b0;
        leave_halt     = 1'b1;
      end
      // Resuming on a breakpoint address must not immediately re-trigger.
      if (leave_halt) begin
        bp_skip_d = 1'b1;
        cause_d   = CAUSE_NONE;
      end
    end else begin
      if (bp_hit) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_BP;
        idx_d   = match_idx;
      end else if (mode_e == MODE_HALT) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_HOST;
      end else if ((state_q == ST_BURST && cpu_enable && remaining_q == CNT_W'(1))
                   || step_done) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RESET_RUN ? ST_FREE : ST_HALTED;
      cause_q        <= RESET_RUN ? CAUSE_NONE : CAUSE_HOST;
      idx_q          <= '0;
      remaining_q    <= '0;
      cycle_count_q  <= '0;
      granted_once_q <= 1'b0;
      bp_skip_q      <= 1'b1;
      odd_q          <= 1'b1;
    end else begin
      state_q        <= state_d;
      cause_q        <= cause_d;
      idx_q          <= idx_d;
      remaining_q    <= remaining_d;
      cycle_count_q  <= cycle_count_d;
      granted_once_q <= granted_once_d;
      bp_skip_q      <= bp_skip_d;
      odd_q          <= odd_d;
    end
  end

  assign halted      = (state_q == ST_HALTED);
  assign halt_cause  = cause_q;
  assign halt_bp_idx = idx_q;
  assign cycle_count = cycle_count_q;
  assign odd_or_even = odd_q;

endmodule
